// File: rtl/q3_logic.sv
// Registered 1-bit full adder: F1 = A^B^C, F2 = majority(A,B,C), one-cycle latency.
// Define Q3_COVERAGE_EN to build the input-combination coverage monitor (seen/all_seen).
module q3_logic (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  output logic       F1,
  output logic       F2,
  output logic       out_valid,
  output logic [7:0] seen,
  output logic       all_seen
);

  logic f1_d, f1_q;
  logic f2_d, f2_q;
  logic out_valid_d, out_valid_q;

  // Sum/carry hold on idle cycles; only out_valid drops.
  always_comb begin
    f1_d        = f1_q;
    f2_d        = f2_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      f1_d = A ^ B ^ C;
      f2_d = (A & B) | (A & C) | (B & C);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f1_q        <= 1'b0;
      f2_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      f1_q        <= f1_d;
      f2_q        <= f2_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign F1        = f1_q;
  assign F2        = f2_q;
  assign out_valid = out_valid_q;

`ifdef Q3_COVERAGE_EN
  logic [7:0] seen_d, seen_q;
  logic       all_seen_d, all_seen_q;

  // all_seen is derived from the next mask so it rises on the edge that fills the last bit.
  always_comb begin
    seen_d = seen_q;
    if (in_valid) seen_d[{A, B, C}] = 1'b1;
    all_seen_d = &seen_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_q     <= 8'h00;
      all_seen_q <= 1'b0;
    end else begin
      seen_q     <= seen_d;
      all_seen_q <= all_seen_d;
    end
  end

  assign seen     = seen_q;
  assign all_seen = all_seen_q;
`else
  assign seen     = 8'h00;
  assign all_seen = 1'b0;
`endif

endmodule

// File: tb/tb_q3_logic.sv
// Directed-vector bench for q3_logic; expected seen/all_seen follow the build's Q3_COVERAGE_EN setting.
module tb_q3_logic;

`ifdef Q3_COVERAGE_EN
  localparam logic [7:0] COV_MASK = 8'hFF;
`else
  localparam logic [7:0] COV_MASK = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst_n, in_valid, a, b, c;
  logic       f1, f2, out_valid, all_seen;
  logic [7:0] seen;

  int n_vec = 0;
  int n_err = 0;

  q3_logic dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(a), .B(b), .C(c),
    .F1(f1), .F2(f2), .out_valid(out_valid),
    .seen(seen), .all_seen(all_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, vld;
    logic [2:0] abc;
    logic       f1, f2, ov;
    logic [7:0] seen;
    logic       all;
    string      nm;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic v, logic [2:0] abc, logic ef2, logic ef1,
                              logic eov, logic [7:0] es, logic ea, string nm);
    vec_t t;
    t.rst_n = r; t.vld = v; t.abc = abc;
    t.f1 = ef1; t.f2 = ef2; t.ov = eov;
    t.seen = es; t.all = ea; t.nm = nm;
    return t;
  endfunction

  task automatic chk1(string nm, string sig, logic act, logic exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %b expected %b", nm, sig, act, exp);
    end
  endtask

  // Drive on the falling edge, check 1 time unit after the next rising edge.
  task automatic step(vec_t t);
    logic [7:0] es;
    logic       ea;
    @(negedge clk);
    rst_n = t.rst_n; in_valid = t.vld; {a, b, c} = t.abc;
    @(posedge clk);
    #1;
    n_vec++;
    es = t.seen & COV_MASK;
    ea = t.all & COV_MASK[0];
    chk1(t.nm, "F1", f1, t.f1);
    chk1(t.nm, "F2", f2, t.f2);
    chk1(t.nm, "out_valid", out_valid, t.ov);
    chk1(t.nm, "all_seen", all_seen, ea);
    if (seen !== es) begin
      n_err++;
      $display("FAIL %s seen: got %h expected %h", t.nm, seen, es);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; {a, b, c} = 3'b111;

    // Reset with valid input asserted, then exhaustive sweep, then hold.
    vecs.push_back(mk(0, 1, 3'b111, 0, 0, 0, 8'h00, 0, "rst0"));
    vecs.push_back(mk(0, 1, 3'b111, 0, 0, 0, 8'h00, 0, "rst1"));
    vecs.push_back(mk(1, 1, 3'b000, 0, 0, 1, 8'h01, 0, "sw000"));
    vecs.push_back(mk(1, 1, 3'b001, 0, 1, 1, 8'h03, 0, "sw001"));
    vecs.push_back(mk(1, 1, 3'b010, 0, 1, 1, 8'h07, 0, "sw010"));
    vecs.push_back(mk(1, 1, 3'b011, 1, 0, 1, 8'h0F, 0, "sw011"));
    vecs.push_back(mk(1, 1, 3'b100, 0, 1, 1, 8'h1F, 0, "sw100"));
    vecs.push_back(mk(1, 1, 3'b101, 1, 0, 1, 8'h3F, 0, "sw101"));
    vecs.push_back(mk(1, 1, 3'b110, 1, 0, 1, 8'h7F, 0, "sw110"));
    vecs.push_back(mk(1, 1, 3'b111, 1, 1, 1, 8'hFF, 1, "sw111"));
    vecs.push_back(mk(1, 1, 3'b011, 1, 0, 1, 8'hFF, 1, "pre_hold"));
    vecs.push_back(mk(1, 0, 3'b111, 1, 0, 0, 8'hFF, 1, "hold0"));
    vecs.push_back(mk(1, 0, 3'b100, 1, 0, 0, 8'hFF, 1, "hold1"));
    vecs.push_back(mk(1, 0, 3'b001, 1, 0, 0, 8'hFF, 1, "hold2"));

    foreach (vecs[i]) step(vecs[i]);

    // Coverage accumulation: 000,111,101 -> A1, then fill remaining five.
    step(mk(0, 0, 3'b000, 0, 0, 0, 8'h00, 0, "cv_rst"));
    step(mk(1, 1, 3'b000, 0, 0, 1, 8'h01, 0, "cv000"));
    step(mk(1, 1, 3'b111, 1, 1, 1, 8'h81, 0, "cv111"));
    step(mk(1, 1, 3'b101, 1, 0, 1, 8'hA1, 0, "cv101"));
    step(mk(1, 1, 3'b101, 1, 0, 1, 8'hA1, 0, "cv101rep"));
    step(mk(1, 0, 3'b010, 1, 0, 0, 8'hA1, 0, "cv_idle"));
    step(mk(1, 1, 3'b001, 0, 1, 1, 8'hA3, 0, "cv001"));
    step(mk(1, 1, 3'b010, 0, 1, 1, 8'hA7, 0, "cv010"));
    step(mk(1, 1, 3'b011, 1, 0, 1, 8'hAF, 0, "cv011"));
    step(mk(1, 1, 3'b100, 0, 1, 1, 8'hBF, 0, "cv100"));
    step(mk(1, 1, 3'b110, 1, 0, 1, 8'hFF, 1, "cv110"));

    // Reset mid-sweep: sample 100 lands on a reset edge and is discarded.
    step(mk(1, 1, 3'b000, 0, 0, 1, 8'hFF, 1, "ms000"));
    step(mk(1, 1, 3'b001, 0, 1, 1, 8'hFF, 1, "ms001"));
    step(mk(1, 1, 3'b011, 1, 0, 1, 8'hFF, 1, "ms011"));
    step(mk(0, 1, 3'b100, 0, 0, 0, 8'h00, 0, "ms_rst100"));
    step(mk(1, 1, 3'b110, 1, 0, 1, 8'h40, 0, "ms110"));
    step(mk(1, 1, 3'b111, 1, 1, 1, 8'hC0, 0, "ms111"));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/q3_logic.md
# q3_logic

Registered 3-input arithmetic/logic cell: samples inputs A, B, C and produces F1 = sum (A xor B xor C) and F2 = carry (majority of A, B, C), i.e. a 1-bit full adder with registered outputs. It is a leaf block for datapaths that need a clocked full-adder bit. An optional coverage monitor records which of the 8 input combinations have been applied, supporting exhaustive truth-table sweeps.

## Interface
Parameters:
- none

Ports:
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk
- in_valid  input  1  A/B/C qualify this cycle
- A  input  1  operand bit (minterm index bit 2)
- B  input  1  operand bit (minterm index bit 1)
- C  input  1  operand/carry-in bit (minterm index bit 0)
- F1  output  1  registered sum: A ^ B ^ C
- F2  output  1  registered carry: (A&B) | (A&C) | (B&C)
- out_valid  output  1  F1/F2 updated from a valid sample on the previous edge
- seen  output  8  coverage mask, bit {A,B,C} set once that combination is sampled (Q3_COVERAGE_EN only)
- all_seen  output  1  &seen (Q3_COVERAGE_EN only)

## Operation
- On a rising clk with rst_n=0: F1=0, F2=0, out_valid=0, seen=8'h00, all_seen=0. Reset overrides in_valid.
- On a rising clk with rst_n=1 and in_valid=1: F1 <= A^B^C; F2 <= majority(A,B,C); out_valid <= 1.
- On a rising clk with rst_n=1 and in_valid=0: F1, F2 hold their previous values; out_valid <= 0.
- Truth table {A,B,C} -> {F2,F1}: 000->00, 001->01, 010->01, 011->10, 100->01, 101->10, 110->10, 111->11.
- F1 and F2 are driven only from flops; no combinational path from inputs to outputs.
- Coverage (when compiled in): on a valid sample, seen[{A,B,C}] <= 1; bits never clear except by reset. all_seen is registered and rises in the same edge that sets the last missing bit. Repeated combinations do not alter seen.
- No undefined-input handling; X on inputs propagates per standard RTL semantics.

## Timing
- Latency: 1 cycle from sampled inputs to F1/F2/out_valid.
- Throughput: one sample per cycle; back-to-back in_valid is supported with no bubbles.
- Reset mid-stream: the sample presented on the reset edge is discarded; outputs read 0 on the following cycle.
- First valid sample after reset release: out_valid=1 exactly one edge later.
- seen/all_seen update on the same edge as F1/F2.

## Configuration
- Macro Q3_COVERAGE_EN.
- Defined: seen[7:0] and all_seen ports and logic exist as described.
- Undefined: seen and all_seen ports are still present but tied to 0. The F1/F2/out_valid behaviour is identical in both builds.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, A=B=C=1 -> F1=0, F2=0, out_valid=0, seen=00.
- Exhaustive sweep: apply {A,B,C}=000..111 on consecutive cycles with in_valid=1 -> {F2,F1} one cycle later = 00,01,01,10,01,10,10,11; out_valid high for 8 cycles.
- Hold: after the sample 011 (F2=1, F1=0), drop in_valid for 3 cycles while toggling A/B/C -> F1=0, F2=1 held, out_valid=0.
- Coverage (Q3_COVERAGE_EN): apply 000,111,101 -> seen=8'hA1, all_seen=0; complete the remaining five -> seen=8'hFF, all_seen=1 on the edge of the eighth distinct value.
- Reset mid-sweep: assert rst_n=0 during the 100 sample -> next cycle all outputs 0, seen=00; resume with 110 -> F2=1, F1=0.
- Build without the macro: run the exhaustive sweep -> same F1/F2 values, seen=00 and all_seen=0 throughout.
